// File: rtl/alu_step_ctrl.sv
// Seven-step stepper and control decoder for the 7-step processor.
// Optional: define ALU_STEP_EARLY_WRAP_EN to wrap to S1 after the last busy step.
module alu_step_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] ir,
    output logic [6:0] step,
    output logic       bus1,
    output logic       iar_e,
    output logic       iar_s,
    output logic       mar_s,
    output logic       ram_e,
    output logic       ram_s,
    output logic       ir_s,
    output logic       tmp_s,
    output logic       acc_e,
    output logic       acc_s,
    output logic [3:0] reg_e,
    output logic [3:0] reg_s,
    output logic [2:0] alu_op
);

    logic       is_alu;
    logic       is_load;
    logic       is_store;
    logic       is_cmp;
    logic [3:0] ra_oh;
    logic [3:0] rb_oh;
    logic       last;
    logic [6:0] step_next;

    assign is_alu   = ir[7];
    assign is_load  = (ir[7:4] == 4'b0000);
    assign is_store = (ir[7:4] == 4'b0001);
    assign is_cmp   = (ir[6:4] == 3'b111);
    assign ra_oh    = 4'b0001 << ir[3:2];
    assign rb_oh    = 4'b0001 << ir[1:0];

`ifdef ALU_STEP_EARLY_WRAP_EN
    // Last busy step: S3 for NOP, S5 for LOAD/STORE, S6 for ALU.
    assign last = (step[5] && is_alu)
               || (step[4] && (is_load || is_store))
               || (step[2] && !is_alu && !is_load && !is_store);
`else
    assign last = 1'b0;
`endif

    assign step_next = last ? 7'b0000001 : {step[5:0], step[6]};

    // Step ring: reset to S1, hold while run is low, else advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            step <= 7'b0000001;
        end else if (run) begin
            step <= step_next;
        end
    end

    // Per-step strobe decode; everything low in reset or when frozen.
    always_comb begin
        bus1   = 1'b0;
        iar_e  = 1'b0;
        iar_s  = 1'b0;
        mar_s  = 1'b0;
        ram_e  = 1'b0;
        ram_s  = 1'b0;
        ir_s   = 1'b0;
        tmp_s  = 1'b0;
        acc_e  = 1'b0;
        acc_s  = 1'b0;
        reg_e  = 4'b0000;
        reg_s  = 4'b0000;
        alu_op = 3'b000;
        if (!reset && run) begin
            unique case (1'b1)
                step[0]: begin
                    bus1  = 1'b1;
                    iar_e = 1'b1;
                    mar_s = 1'b1;
                    acc_s = 1'b1;
                end
                step[1]: begin
                    ram_e = 1'b1;
                    ir_s  = 1'b1;
                end
                step[2]: begin
                    acc_e = 1'b1;
                    iar_s = 1'b1;
                end
                step[3]: begin
                    if (is_alu) begin
                        reg_e = rb_oh;
                        tmp_s = 1'b1;
                    end else if (is_load || is_store) begin
                        reg_e = ra_oh;
                        mar_s = 1'b1;
                    end
                end
                step[4]: begin
                    if (is_alu) begin
                        reg_e  = ra_oh;
                        alu_op = ir[6:4];
                        acc_s  = 1'b1;
                    end else if (is_load) begin
                        ram_e = 1'b1;
                        reg_s = rb_oh;
                    end else if (is_store) begin
                        reg_e = rb_oh;
                        ram_s = 1'b1;
                    end
                end
                step[5]: begin
                    if (is_alu) begin
                        acc_e = 1'b1;
                        reg_s = is_cmp ? 4'b0000 : rb_oh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
